mem_boot_ctrl: RTL and testbench

//  Boot/run sequencer and shared-port arbiter for the FPGA top level.
//  - Owns the dmem/imem write ports: program loader during boot, pipeline afterwards.
//  - Holds the pipeline in reset until loading completes.
//  - Decodes the MMIO stores (UART byte, finish flag).
//  - Buffers UART bytes in a small queue and paces them into the UART TX handshake.

---
 rtl/mem_boot_ctrl_pkg.sv | 16 +
 rtl/sync_fifo_8b.sv | 48 ++++
 rtl/mem_boot_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_boot_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_boot_ctrl_pkg.sv
// rtl/mem_boot_ctrl_pkg.sv - sequencer state encoding and default MMIO map
package mem_boot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [31:0] DEF_UART_ADDR   = 32'h0000_0000;
  localparam logic [31:0] DEF_FINISH_ADDR = 32'h0000_0008;
  localparam int          IMEM_AW         = 9;

endpackage

// File: rtl/sync_fifo_8b.sv
// rtl/sync_fifo_8b.sv - byte queue; a push into a full queue lands only if a pop happens in the same cycle
module sync_fifo_8b #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/mem_boot_ctrl.sv
// rtl/mem_boot_ctrl.sv - boot/run sequencer, dmem/imem port arbiter, MMIO decode and paced UART TX
module mem_boot_ctrl
  import mem_boot_ctrl_pkg::*;
#(
  parameter int                  ADDR_LEN    = 32,
  parameter int                  DATA_LEN    = 32,
  parameter logic [ADDR_LEN-1:0] UART_ADDR   = DEF_UART_ADDR[ADDR_LEN-1:0],
  parameter logic [ADDR_LEN-1:0] FINISH_ADDR = DEF_FINISH_ADDR[ADDR_LEN-1:0],
  parameter int                  RST_HOLD    = 4,
  parameter int                  TXQ_DEPTH   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_x_i,
  input  logic                 ld_done_i,
  input  logic [ADDR_LEN-1:0]  ld_addr_i,
  input  logic [DATA_LEN-1:0]  ld_wdata_i,
  input  logic                 ld_we32_i,
  input  logic                 ld_we128_i,
  input  logic [ADDR_LEN-1:0]  core_addr_i,
  input  logic [DATA_LEN-1:0]  core_wdata_i,
  input  logic                 core_we_i,
  input  logic [ADDR_LEN-1:0]  pc_i,
  output logic                 core_reset_o,
  output logic [ADDR_LEN-1:0]  dmem_addr_o,
  output logic [DATA_LEN-1:0]  dmem_wdata_o,
  output logic                 dmem_we_o,
  output logic [IMEM_AW-1:0]   imem_addr_o,
  output logic                 imem_we_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_we_o,
  input  logic                 tx_ready_i,
  output logic                 finished_o,
  output logic                 txq_ovf_o,
  output logic [7:0]           led_o
);

  localparam int CW = $clog2(TXQ_DEPTH) + 1;
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          tx_we_q, tx_we_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          finished_q, finished_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    led_q, led_d;

  logic          q_full, q_empty;
  logic [7:0]    q_head;
  logic [CW-1:0] q_count_unused;
  logic          uart_hit, finish_hit, push_req, pop_issue;
  logic          unused_addr_bits;

  assign uart_hit   = core_we_i && (core_addr_i == UART_ADDR);
  assign finish_hit = core_we_i && (core_addr_i == FINISH_ADDR);
  assign push_req   = (state_q == ST_RUN) && uart_hit;
  // Empty is sampled before this cycle's push, so a push into an empty queue never pops.
  assign pop_issue  = !q_empty && tx_ready_i && !tx_we_q;

  assign unused_addr_bits = ^{pc_i[ADDR_LEN-1:13], pc_i[3:0],
                              ld_addr_i[ADDR_LEN-1:13], ld_addr_i[3:0], q_count_unused};

  sync_fifo_8b #(.DEPTH(TXQ_DEPTH)) u_txq (
    .clk_i   (clk_i),
    .rst_n_i (rst_x_i),
    .push_i  (push_req),
    .data_i  (core_wdata_i[7:0]),
    .pop_i   (pop_issue),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count_unused)
  );

  always_ff @(posedge clk_i or negedge rst_x_i) begin
    if (!rst_x_i) begin
      state_q    <= ST_LOAD;
      hold_q     <= '0;
      tx_we_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      finished_q <= 1'b0;
      ovf_q      <= 1'b0;
      led_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      tx_we_q    <= tx_we_d;
      tx_data_q  <= tx_data_d;
      finished_q <= finished_d;
      ovf_q      <= ovf_d;
      led_q      <= led_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    finished_d   = finished_q;
    ovf_d        = ovf_q;
    led_d        = led_q;
    tx_we_d      = pop_issue;
    tx_data_d    = pop_issue ? q_head : tx_data_q;
    core_reset_o = 1'b1;
    dmem_addr_o  = ld_addr_i;
    dmem_wdata_o = ld_wdata_i;
    dmem_we_o    = 1'b0;
    imem_addr_o  = ld_addr_i[12:4];
    imem_we_o    = 1'b0;

    if (state_q == ST_RUN || state_q == ST_DRAIN || state_q == ST_DONE) begin
      core_reset_o = 1'b0;
      dmem_addr_o  = core_addr_i;
      dmem_wdata_o = core_wdata_i;
      dmem_we_o    = core_we_i;
      imem_addr_o  = pc_i[12:4];
    end

    case (state_q)
      ST_LOAD: begin
        dmem_we_o = ld_we32_i;
        imem_we_o = ld_we128_i;
        if (ld_done_i) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        if (hold_q == HW'(RST_HOLD - 1)) state_d = ST_RUN;
        else                             hold_d  = hold_q + HW'(1);
      end
      ST_RUN: begin
        if (push_req) begin
          led_d[6:0] = core_wdata_i[6:0];
          if (q_full && !pop_issue) ovf_d = 1'b1;
        end
        if (finish_hit) begin
          finished_d = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (q_empty && !tx_we_q) begin
          state_d  = ST_DONE;
          led_d[7] = 1'b1;
        end
      end
      ST_DONE: ;
      default: state_d = ST_LOAD;
    endcase
  end

  assign tx_we_o    = tx_we_q;
  assign tx_data_o  = tx_data_q;
  assign finished_o = finished_q;
  assign txq_ovf_o  = ovf_q;
  assign led_o      = led_q;

endmodule

// File: tb/tb_mem_boot_ctrl.sv
// tb/tb_mem_boot_ctrl.sv - scenario tasks against a byte-queue scoreboard for mem_boot_ctrl
module tb_mem_boot_ctrl;

  localparam int RST_HOLD = 4;
  localparam int DEPTH    = 8;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        ld_done, ld_we32, ld_we128, core_we, tx_ready;
  logic [31:0] ld_addr, ld_wdata, core_addr, core_wdata, pc;
  logic        core_reset, dmem_we, imem_we, tx_we, finished, txq_ovf;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [8:0]  imem_addr;
  logic [7:0]  tx_data, led;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [7:0] cap_q[$];
  int         cap_t[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (tx_we === 1'b1) begin
    cap_q.push_back(tx_data);
    cap_t.push_back(cyc);
  end

  mem_boot_ctrl #(.RST_HOLD(RST_HOLD), .TXQ_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_x_i(rst_x), .ld_done_i(ld_done), .ld_addr_i(ld_addr),
    .ld_wdata_i(ld_wdata), .ld_we32_i(ld_we32), .ld_we128_i(ld_we128),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_we_i(core_we), .pc_i(pc),
    .core_reset_o(core_reset), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
    .dmem_we_o(dmem_we), .imem_addr_o(imem_addr), .imem_we_o(imem_we),
    .tx_data_o(tx_data), .tx_we_o(tx_we), .tx_ready_i(tx_ready),
    .finished_o(finished), .txq_ovf_o(txq_ovf), .led_o(led)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_x = 1'b0;
    ld_done = 0; ld_we32 = 0; ld_we128 = 0; core_we = 0; tx_ready = 0;
    ld_addr = 0; ld_wdata = 0; core_addr = 32'h400; core_wdata = 0; pc = 0;
    repeat (2) tick();
    cap_q.delete();
    cap_t.delete();
    rst_x = 1'b1;
    tick();
  endtask

  task automatic boot();
    int n;
    ld_done = 1'b1;
    n = 0;
    while (core_reset !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (core_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_timeout: core_reset=%b required 0", core_reset);
    end
  endtask

  task automatic uart_store(input logic [7:0] b);
    core_addr  = 32'h0;
    core_wdata = {$urandom_range(0, 255) & 32'hFF, 16'h0, b};
    core_we    = 1'b1;
    tick();
    core_we    = 1'b0;
    core_addr  = 32'h400;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (cap_q.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_x = 1'b0;
    ld_done = 0; ld_we32 = 1; ld_we128 = 0; core_we = 0; tx_ready = 1;
    ld_addr = 32'h40; ld_wdata = 0; core_addr = 0; core_wdata = 0; pc = 0;
    #3;
    n_cmp++;
    if ({core_reset, tx_we, tx_data, finished, txq_ovf, led} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rst=%b we=%b data=%h fin=%b ovf=%b led=%h required 1 0 00 0 0 00",
               core_reset, tx_we, tx_data, finished, txq_ovf, led);
    end
    n_cmp++;
    if (dmem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_load_mux: dmem_we=%b required 1", dmem_we);
    end
    do_reset();
  endtask

  task automatic test_boot();
    int hold;
    logic [31:0] w;
    do_reset();
    w = $urandom();
    ld_we32 = 1; ld_addr = 32'h40; ld_wdata = w;
    #1;
    n_cmp++;
    if ({dmem_we, imem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b0, 32'h40, w}) begin
      n_fail++;
      $display("FAIL boot_we32: we=%b iwe=%b addr=%h data=%h required 1 0 00000040 %h",
               dmem_we, imem_we, dmem_addr, dmem_wdata, w);
    end
    tick();
    ld_we32 = 0; ld_we128 = 1; ld_addr = 32'h100;
    #1;
    n_cmp++;
    if ({imem_we, dmem_we, imem_addr} !== {1'b1, 1'b0, 9'h010}) begin
      n_fail++;
      $display("FAIL boot_we128: iwe=%b we=%b iaddr=%h required 1 0 010", imem_we, dmem_we, imem_addr);
    end
    tick();
    ld_we128 = 0; ld_we32 = 1; ld_done = 1;
    hold = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (core_reset !== 1'b1) break;
      hold++;
      n_cmp++;
      if (dmem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_we_gated: dmem_we=%b required 0", dmem_we);
      end
    end
    n_cmp++;
    if (hold != RST_HOLD) begin
      n_fail++;
      $display("FAIL hold_cycles: got %0d required %0d", hold, RST_HOLD);
    end
    ld_we32 = 0; ld_done = 0;
    tick();
    n_cmp++;
    if (core_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_done_fall: core_reset=%b required 0", core_reset);
    end
    w = $urandom();
    core_addr = 32'h200; core_wdata = w; core_we = 1; pc = $urandom(); ld_we128 = 1;
    #1;
    n_cmp++;
    if ({dmem_we, dmem_addr, dmem_wdata, imem_addr, imem_we} !== {1'b1, 32'h200, w, pc[12:4], 1'b0}) begin
      n_fail++;
      $display("FAIL run_mux: we=%b addr=%h data=%h iaddr=%h iwe=%b required 1 00000200 %h %h 0",
               dmem_we, dmem_addr, dmem_wdata, imem_addr, imem_we, w, pc[12:4]);
    end
    tick();
    core_we = 0; ld_we128 = 0;
  endtask

  task automatic test_uart();
    do_reset();
    boot();
    tx_ready = 1;
    uart_store(8'h41);
    uart_store(8'h42);
    wait_bytes(2, 30);
    repeat (3) tick();
    n_cmp++;
    if (cap_q.size() != 2) begin
      n_fail++;
      $display("FAIL uart_count: got %0d required 2", cap_q.size());
    end else begin
      n_cmp++;
      if ({cap_q[0], cap_q[1]} !== 16'h4142) begin
        n_fail++;
        $display("FAIL uart_bytes: got %h %h required 41 42", cap_q[0], cap_q[1]);
      end
      n_cmp++;
      if (cap_t[1] - cap_t[0] < 2) begin
        n_fail++;
        $display("FAIL uart_gap: got %0d required >=2", cap_t[1] - cap_t[0]);
      end
    end
    n_cmp++;
    if (led !== 8'h42) begin
      n_fail++;
      $display("FAIL uart_led: got %h required 42", led);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    do_reset();
    boot();
    tx_ready = 0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom());
      if (i < DEPTH) exp_q.push_back(b);
      uart_store(b);
    end
    n_cmp++;
    if ({txq_ovf, 8'(cap_q.size())} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL ovf_flag: ovf=%b emitted=%0d required 1 0", txq_ovf, cap_q.size());
    end
    tx_ready = 1;
    wait_bytes(DEPTH + 1, 60);
    n_cmp++;
    if (cap_q.size() != DEPTH) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d required %0d", cap_q.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ovf_byte%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_finish();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    do_reset();
    boot();
    tx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom());
      exp_q.push_back(b);
      uart_store(b);
    end
    core_addr = 32'h8; core_wdata = $urandom(); core_we = 1;
    #1;
    n_cmp++;
    if (dmem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL finish_to_dmem: dmem_we=%b required 1", dmem_we);
    end
    tick();
    core_we = 0;
    n_cmp++;
    if (finished !== 1'b1) begin
      n_fail++;
      $display("FAIL finish_flag: got %b required 1", finished);
    end
    uart_store(8'h5A);
    repeat (3) tick();
    n_cmp++;
    if ({led, 8'(cap_q.size())} !== {1'b0, exp_q[2][6:0], 8'd0}) begin
      n_fail++;
      $display("FAIL finish_led_hold: led=%h emitted=%0d required %h 0",
               led, cap_q.size(), {1'b0, exp_q[2][6:0]});
    end
    tx_ready = 1;
    wait_bytes(4, 40);
    repeat (4) tick();
    n_cmp++;
    if (cap_q.size() != 3) begin
      n_fail++;
      $display("FAIL finish_count: got %0d required 3", cap_q.size());
    end
    for (int i = 0; i < 3 && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL finish_byte%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (led[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL done_led7: got %b required 1", led[7]);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    do_reset();
    boot();
    tx_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom());
      exp_q.push_back(b);
      uart_store(b);
    end
    b = 8'($urandom());
    exp_q.push_back(b);
    tx_ready = 1; core_addr = 32'h0; core_wdata = {24'h0, b}; core_we = 1;
    tick();
    n_cmp++;
    if (txq_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL pushpop_no_ovf: got %b required 0", txq_ovf);
    end
    core_wdata = $urandom();
    tick();
    core_we = 0;
    n_cmp++;
    if (txq_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL pushpop_still_full: ovf=%b required 1", txq_ovf);
    end
    wait_bytes(DEPTH + 2, 60);
    n_cmp++;
    if (cap_q.size() != DEPTH + 1) begin
      n_fail++;
      $display("FAIL pushpop_count: got %0d required %0d", cap_q.size(), DEPTH + 1);
    end
    for (int i = 0; i <= DEPTH && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL pushpop_byte%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int n, pre;
    do_reset();
    boot();
    tx_ready = 0;
    for (int i = 0; i < 3; i++) uart_store(8'($urandom()));
    tx_ready = 1;
    n = 0;
    while (tx_we !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    n_cmp++;
    if (tx_we !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_strobe_timeout: tx_we=%b required 1", tx_we);
    end
    rst_x = 1'b0;
    #1;
    n_cmp++;
    if ({core_reset, tx_we, tx_data} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL midrst_immediate: rst=%b we=%b data=%h required 1 0 00", core_reset, tx_we, tx_data);
    end
    tick();
    rst_x = 1'b1;
    ld_done = 0;
    pre = cap_q.size();
    repeat (20) tick();
    ld_we32 = 1;
    #1;
    n_cmp++;
    if ({8'(cap_q.size() - pre), core_reset, dmem_we} !== {8'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_load: new_bytes=%0d rst=%b we=%b required 0 1 1",
               cap_q.size() - pre, core_reset, dmem_we);
    end
    ld_we32 = 0;
    boot();
    repeat (20) tick();
    n_cmp++;
    if (cap_q.size() != pre) begin
      n_fail++;
      $display("FAIL midrst_discard: new_bytes=%0d required 0", cap_q.size() - pre);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b, last;
    int r;
    do_reset();
    boot();
    last = 8'h00;
    for (int i = 0; i < 400; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 3);
      if (r == 0 && (exp_q.size() - cap_q.size()) < DEPTH) begin
        b = 8'($urandom());
        exp_q.push_back(b);
        last = b;
        core_addr = 32'h0; core_wdata = {24'($urandom()), b}; core_we = 1;
      end else if (r == 1) begin
        core_addr = 32'h100 + 32'($urandom_range(0, 63) * 4); core_wdata = $urandom(); core_we = 1;
      end else begin
        core_we = 0;
      end
      tick();
    end
    core_we = 0; tx_ready = 1;
    wait_bytes(exp_q.size() + 1, 80);
    n_cmp++;
    if (cap_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_byte%0d: got %h required %h", i, cap_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < cap_t.size(); i++) begin
      n_cmp++;
      if (cap_t[i] - cap_t[i-1] < 2) begin
        n_fail++;
        $display("FAIL rand_gap%0d: got %0d required >=2", i, cap_t[i] - cap_t[i-1]);
      end
    end
    n_cmp++;
    if ({txq_ovf, led} !== {1'b0, 1'b0, last[6:0]}) begin
      n_fail++;
      $display("FAIL rand_flags: ovf=%b led=%h required 0 %h", txq_ovf, led, {1'b0, last[6:0]});
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_uart();
    test_overflow();
    test_finish();
    test_full_push_pop();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
